// File: rtl/alu_pkg.sv
// Shared function codes and group-decode helpers for the registered ALU.
package alu_pkg;

    localparam logic [3:0] FnAdd  = 4'b0000;
    localparam logic [3:0] FnSub  = 4'b0001;
    localparam logic [3:0] FnId   = 4'b0010;
    localparam logic [3:0] FnNot  = 4'b0011;
    localparam logic [3:0] FnAnd  = 4'b0100;
    localparam logic [3:0] FnOr   = 4'b0101;
    localparam logic [3:0] FnNand = 4'b0110;
    localparam logic [3:0] FnNor  = 4'b0111;
    localparam logic [3:0] FnXor  = 4'b1000;
    localparam logic [3:0] FnXnor = 4'b1001;
    localparam logic [3:0] FnLls  = 4'b1010;
    localparam logic [3:0] FnLrs  = 4'b1011;
    localparam logic [3:0] FnAls  = 4'b1100;
    localparam logic [3:0] FnArs  = 4'b1101;
    localparam logic [3:0] FnTcp  = 4'b1110;
    localparam logic [3:0] FnZero = 4'b1111;

    function automatic logic is_addsub(input logic [3:0] fn);
        return (fn == FnAdd) || (fn == FnSub);
    endfunction

    function automatic logic is_logic(input logic [3:0] fn);
        return (fn >= FnAnd) && (fn <= FnXnor);
    endfunction

    function automatic logic is_shift(input logic [3:0] fn);
        return (fn >= FnLls) && (fn <= FnArs);
    endfunction

    // NOT lives here with ID/TCP/ZERO since it only uses A.
    function automatic logic is_misc(input logic [3:0] fn);
        return (fn == FnId) || (fn == FnNot) || (fn == FnTcp) || (fn == FnZero);
    endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Combinational ALU: four function groups, each zero outside its group, OR-merged.
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int unsigned data_width = 16
) (
    input  logic [data_width-1:0] A,
    input  logic [data_width-1:0] B,
    input  logic [3:0]            FuncCode,
    output logic [data_width-1:0] result,
    output logic                  ovf
);

    logic [data_width-1:0] as_res, lg_res, sh_res, mc_res;
    logic                  as_ovf;
    logic                  sign_a, sign_b, sign_c;

    assign sign_a = A[data_width-1];
    assign sign_b = B[data_width-1];
    assign sign_c = as_res[data_width-1];

    always_comb begin
        as_res = '0;
        as_ovf = 1'b0;
        if (is_addsub(FuncCode)) begin
            if (FuncCode == FnSub) begin
                as_res = A - B;
                as_ovf = (sign_a != sign_b) && (sign_c != sign_a);
            end else begin
                as_res = A + B;
                as_ovf = (sign_a == sign_b) && (sign_c != sign_a);
            end
        end
    end

    always_comb begin
        lg_res = '0;
        if (is_logic(FuncCode)) begin
            unique case (FuncCode)
                FnAnd:   lg_res = A & B;
                FnOr:    lg_res = A | B;
                FnNand:  lg_res = ~(A & B);
                FnNor:   lg_res = ~(A | B);
                FnXor:   lg_res = A ^ B;
                FnXnor:  lg_res = ~(A ^ B);
                default: lg_res = '0;
            endcase
        end
    end

    always_comb begin
        sh_res = '0;
        if (is_shift(FuncCode)) begin
            unique case (FuncCode)
                FnLls, FnAls: sh_res = {A[data_width-2:0], 1'b0};
                FnLrs:        sh_res = {1'b0, A[data_width-1:1]};
                FnArs:        sh_res = {A[data_width-1], A[data_width-1:1]};
                default:      sh_res = '0;
            endcase
        end
    end

    // TCP deliberately raises no overflow, even for the most-negative value.
    always_comb begin
        mc_res = '0;
        if (is_misc(FuncCode)) begin
            unique case (FuncCode)
                FnId:    mc_res = A;
                FnNot:   mc_res = ~A;
                FnTcp:   mc_res = ~A + data_width'(1);
                default: mc_res = '0;
            endcase
        end
    end

    assign result = as_res | lg_res | sh_res | mc_res;
    assign ovf    = as_ovf;

endmodule

// File: rtl/registered_alu.sv
// Execute-stage ALU: samples operands on in_valid and registers result, overflow and valid.
module registered_alu
    import alu_pkg::*;
#(
    parameter int unsigned data_width = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [data_width-1:0] A,
    input  logic [data_width-1:0] B,
    input  logic [3:0]            FuncCode,
    output logic [data_width-1:0] C,
    output logic                  OverflowFlag,
    output logic                  out_valid
);

    logic [data_width-1:0] core_res;
    logic                  core_ovf;

    logic [data_width-1:0] c_q, c_d;
    logic                  ovf_q, ovf_d;
    logic                  valid_q, valid_d;

    alu_comb_core #(
        .data_width(data_width)
    ) u_core (
        .A       (A),
        .B       (B),
        .FuncCode(FuncCode),
        .result  (core_res),
        .ovf     (core_ovf)
    );

    // Result and flag hold across idle cycles; only out_valid drops.
    always_comb begin
        c_d     = c_q;
        ovf_d   = ovf_q;
        valid_d = in_valid;
        if (in_valid) begin
            c_d   = core_res;
            ovf_d = core_ovf;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_q     <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            c_q     <= c_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign C            = c_q;
    assign OverflowFlag = ovf_q;
    assign out_valid    = valid_q;

endmodule

// File: tb/tb_registered_alu.sv
// Scoreboard bench for registered_alu: directed and random stimulus against a reference model.
module tb_registered_alu;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [3:0]  func_code = '0;
    logic [15:0] c;
    logic        overflow_flag;
    logic        out_valid;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [15:0] c;
        logic        of;
        int          due;
        string       nm;
    } exp_t;

    typedef struct {
        logic [3:0]  fn;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
        logic        of;
        string       nm;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[$];

    registered_alu #(
        .data_width(16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .A           (a),
        .B           (b),
        .FuncCode    (func_code),
        .C           (c),
        .OverflowFlag(overflow_flag),
        .out_valid   (out_valid)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference: signed results out of the 16-bit range overflow; everything else wraps.
    function automatic void model(input logic [3:0] fn, input logic [15:0] ia, input logic [15:0] ib,
                                  output logic [15:0] oc, output logic oof);
        longint sa, sb, r;
        sa  = longint'($signed(ia));
        sb  = longint'($signed(ib));
        r   = 0;
        oof = 1'b0;
        oc  = '0;
        case (fn)
            4'd0: begin r = sa + sb; oof = (r > 32767) || (r < -32768); oc = r[15:0]; end
            4'd1: begin r = sa - sb; oof = (r > 32767) || (r < -32768); oc = r[15:0]; end
            4'd2: oc = ia;
            4'd3: oc = 16'hFFFF - ia;
            4'd4: oc = ia & ib;
            4'd5: oc = ia | ib;
            4'd6: oc = ~(ia & ib);
            4'd7: oc = ~(ia | ib);
            4'd8: oc = ia ^ ib;
            4'd9: oc = ~(ia ^ ib);
            4'd10, 4'd12: begin r = longint'(ia) * 2; oc = r[15:0]; end
            4'd11: begin r = longint'(ia) / 2; oc = r[15:0]; end
            4'd13: begin r = (sa < 0) ? (sa - 1) / 2 : sa / 2; oc = r[15:0]; end
            4'd14: begin r = 65536 - longint'(ia); oc = r[15:0]; end
            default: oc = '0;
        endcase
    endfunction

    task automatic issue(input logic [3:0] fn, input logic [15:0] ia, input logic [15:0] ib,
                         input logic [15:0] ec, input logic eof, input string nm);
        exp_t e;
        in_valid  = 1'b1;
        func_code = fn;
        a         = ia;
        b         = ib;
        e.c       = ec;
        e.of      = eof;
        e.due     = cyc + 1;
        e.nm      = nm;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic issue_model(input logic [3:0] fn, input logic [15:0] ia, input logic [15:0] ib,
                               input string nm);
        logic [15:0] ec;
        logic        eof;
        model(fn, ia, ib, ec, eof);
        issue(fn, ia, ib, ec, eof, nm);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic logic [15:0] pick_operand();
        logic [15:0] corners [5];
        corners = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return 16'($urandom);
    endfunction

    // Monitor: each entry must appear exactly on its due cycle; anything else is an error.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                e = sb_q.pop_front();
                checks++;
                if (!out_valid || c !== e.c || overflow_flag !== e.of) begin
                    failures++;
                    $display("FAIL %s actual valid=%b C=%h OF=%b required valid=1 C=%h OF=%b",
                             e.nm, out_valid, c, overflow_flag, e.c, e.of);
                end
            end else if (out_valid) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual valid=1 C=%h required valid=0", c);
            end
        end
    end

    initial begin
        logic [3:0]  fn;
        logic [15:0] ra, rb;

        vecs.push_back('{4'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, "add_ovf"});
        vecs.push_back('{4'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, "add_wrap"});
        vecs.push_back('{4'd1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, "sub_ovf"});
        vecs.push_back('{4'd1, 16'h0005, 16'h0003, 16'h0002, 1'b0, "sub_plain"});
        vecs.push_back('{4'd4, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, "and"});
        vecs.push_back('{4'd5, 16'hF0F0, 16'hFF00, 16'hFFF0, 1'b0, "or"});
        vecs.push_back('{4'd6, 16'hF0F0, 16'hFF00, 16'h0FFF, 1'b0, "nand"});
        vecs.push_back('{4'd7, 16'hF0F0, 16'hFF00, 16'h000F, 1'b0, "nor"});
        vecs.push_back('{4'd8, 16'hF0F0, 16'hFF00, 16'h0FF0, 1'b0, "xor"});
        vecs.push_back('{4'd9, 16'hF0F0, 16'hFF00, 16'hF00F, 1'b0, "xnor"});
        vecs.push_back('{4'd3, 16'hF0F0, 16'hFF00, 16'h0F0F, 1'b0, "not"});
        vecs.push_back('{4'd10, 16'h8001, 16'hFFFF, 16'h0002, 1'b0, "lls"});
        vecs.push_back('{4'd11, 16'h8001, 16'hFFFF, 16'h4000, 1'b0, "lrs"});
        vecs.push_back('{4'd12, 16'h8001, 16'hFFFF, 16'h0002, 1'b0, "als"});
        vecs.push_back('{4'd13, 16'h8001, 16'hFFFF, 16'hC000, 1'b0, "ars"});
        vecs.push_back('{4'd2, 16'hABCD, 16'h1234, 16'hABCD, 1'b0, "id"});
        vecs.push_back('{4'd14, 16'h0001, 16'h7FFF, 16'hFFFF, 1'b0, "tcp_one"});
        vecs.push_back('{4'd14, 16'h8000, 16'h8000, 16'h8000, 1'b0, "tcp_min"});
        vecs.push_back('{4'd15, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, "zero"});

        // Reset state, asserted between edges.
        #1 reset = 1'b1;
        #1;
        check("reset_c", 32'(c), 32'h0);
        check("reset_of", 32'(overflow_flag), 32'h0);
        check("reset_valid", 32'(out_valid), 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Directed table, issued back-to-back.
        foreach (vecs[i]) issue(vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].of, vecs[i].nm);

        // Hold: C sticks while in_valid is low even as A changes.
        issue(4'd0, 16'h0001, 16'h0001, 16'h0002, 1'b0, "add_1_1");
        for (int i = 0; i < 3; i++) begin
            a         = 16'($urandom);
            func_code = 4'd0;
            @(posedge clk);
            #1;
            check("hold_c", 32'(c), 32'h0002);
            check("hold_valid", 32'(out_valid), 32'h0);
        end

        // Random traffic with occasional idle gaps.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            fn = 4'($urandom_range(0, 15));
            ra = pick_operand();
            rb = pick_operand();
            issue_model(fn, ra, rb, "random");
        end
        @(posedge clk);
        #1;

        // Asynchronous reset mid-cycle after loading 0x1234.
        in_valid  = 1'b1;
        func_code = 4'd2;
        a         = 16'h1234;
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("pre_reset_c", 32'(c), 32'h1234);
        #1 reset = 1'b1;
        #1;
        check("async_reset_c", 32'(c), 32'h0);
        check("async_reset_of", 32'(overflow_flag), 32'h0);
        check("async_reset_valid", 32'(out_valid), 32'h0);

        // in_valid during reset is dropped.
        in_valid  = 1'b1;
        func_code = 4'd0;
        a         = 16'h7FFF;
        b         = 16'h0001;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        check("reset_wins_c", 32'(c), 32'h0);
        check("reset_wins_valid", 32'(out_valid), 32'h0);
        @(posedge clk);
        #1;
        check("reset_wins_after_valid", 32'(out_valid), 32'h0);

        // Post-reset: first valid edge loads a result.
        issue_model(4'd0, 16'h7FFF, 16'h0001, "post_reset_add");
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sb_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
